// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM state encoding,
// default geometry and timing, and a small index-width helper.
package keypad_pkg;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_DWELL    = 4;
    localparam int DEF_DEBOUNCE = 20;
    localparam int CODE_W       = 4;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines; resets to
// all-ones so an idle (pulled-high) keypad is seen during and after reset.
module col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk1k,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk1k or negedge rst) begin
        if (!rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller: drives one row low at a time,
// debounces press and release, and reports the accepted key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int DWELL    = DEF_DWELL,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic              clk1k,
    input  logic              rst,
    input  logic [COLS-1:0]   col_n,
    output logic [ROWS-1:0]   row_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down
);

    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);
    localparam int DW = $clog2(DWELL + 1);
    localparam int BW = $clog2(DEBOUNCE + 1);

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE - 1);

    state_t              r_state,     w_state_nxt;
    logic [RW-1:0]       r_row,       w_row_nxt;
    logic [DW-1:0]       r_dwell,     w_dwell_nxt;
    logic [BW-1:0]       r_cnt,       w_cnt_nxt;
    logic [COLS-1:0]     r_pattern,   w_pattern_nxt;
    logic [CW-1:0]       r_col_idx,   w_col_idx_nxt;
    logic [CODE_W-1:0]   r_key_code,  w_key_code_nxt;
    logic                r_key_valid, w_key_valid_nxt;
    logic                r_key_down,  w_key_down_nxt;

    logic [COLS-1:0]     w_cols;
    logic [CW-1:0]       w_low_idx;
    logic                w_any_low;
    logic [RW-1:0]       w_row_inc;
    logic [CODE_W-1:0]   w_code;

    col_sync #(
        .WIDTH (COLS)
    ) u_col_sync (
        .clk1k (clk1k),
        .rst   (rst),
        .i_d   (col_n),
        .o_q   (w_cols)
    );

    // Lowest-numbered closed column wins when several keys share a row.
    always_comb begin
        w_low_idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!w_cols[i]) begin
                w_low_idx = CW'(i);
            end
        end
    end

    assign w_any_low = ~&w_cols;
    assign w_row_inc = (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
    assign w_code    = CODE_W'(int'(r_row) * COLS + int'(r_col_idx));

    // NOTE: every variable gets its hold value before the case so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_dwell_nxt     = r_dwell;
        w_cnt_nxt       = r_cnt;
        w_pattern_nxt   = r_pattern;
        w_col_idx_nxt   = r_col_idx;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_down_nxt  = r_key_down;

        case (r_state)
            S_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_any_low) begin
                        w_pattern_nxt = w_cols;
                        w_col_idx_nxt = w_low_idx;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_DEBOUNCE;
                    end else begin
                        w_row_nxt = w_row_inc;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end

            S_DEBOUNCE: begin
                if (w_cols != r_pattern) begin
                    w_state_nxt = S_SCAN;
                    w_row_nxt   = w_row_inc;
                    w_dwell_nxt = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt     = S_PRESSED;
                    w_key_code_nxt  = w_code;
                    w_key_valid_nxt = 1'b1;
                    w_key_down_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + BW'(1);
                end
            end

            S_PRESSED: begin
                // Row stays frozen, so other keys in this row cannot start a new press.
                if (!w_any_low) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (w_any_low) begin
                    w_state_nxt = S_PRESSED;
                end else if (r_cnt == DB_LAST) begin
                    w_key_down_nxt = 1'b0;
                    w_state_nxt    = S_SCAN;
                    w_row_nxt      = w_row_inc;
                    w_dwell_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + BW'(1);
                end
            end

            default: begin
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    // NOTE: the latched pattern and key code are ordinary registers, so they
    // take the asynchronous reset like every other flop in the block.
    always_ff @(posedge clk1k or negedge rst) begin
        if (!rst) begin
            r_state     <= S_SCAN;
            r_row       <= '0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_pattern   <= '1;
            r_col_idx   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_dwell     <= w_dwell_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pattern   <= w_pattern_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_down  <= w_key_down_nxt;
        end
    end

    assign row_n     = ~(ROWS'(1) << r_row);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 4x4 switch matrix model pulls a column
// low only while its key is closed and its row is driven.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic       clk1k = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = '0;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          pulse_cnt    = 0;
    logic [3:0]  last_code    = '0;

    keypad_scanner #(
        .ROWS     (4),
        .COLS     (4),
        .DWELL    (4),
        .DEBOUNCE (20)
    ) dut (
        .clk1k     (clk1k),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk1k = ~clk1k;

    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    // A pulse wider than one cycle is counted twice and trips the count checks.
    always @(negedge clk1k) begin
        if (key_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            last_code <= key_code;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk1k);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 80 && key_down !== 1'b0; i++) tick();
        tests_run++;
        if (key_down !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: key_down=%b expected 0", name, key_down);
        end
        tick(8);
    endtask

    task automatic test_reset();
        logic [3:0] exp_rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst  = 1'b0;
        keys = '0;
        tick(3);
        tests_run += 4;
        if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL rst_row_n: got %b expected 1110", row_n); end
        if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_key_valid: got %b expected 0", key_valid); end
        if (key_down !== 1'b0) begin tests_failed++; $display("FAIL rst_key_down: got %b expected 0", key_down); end
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL rst_key_code: got %0d expected 0", key_code); end
        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k % 4 == 0) begin
                tests_run++;
                if (row_n !== exp_rows[k/4]) begin
                    tests_failed++;
                    $display("FAIL scan_step%0d: row_n=%b expected %b", k, row_n, exp_rows[k/4]);
                end
            end
            if (k == 3) begin
                tests_run++;
                if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL scan_dwell: row_n=%b expected 1110", row_n); end
            end
            tick();
        end
    endtask

    task automatic test_clean_press();
        int base = pulse_cnt;
        keys[9] = 1'b1;
        for (int i = 0; i < 60 && pulse_cnt == base; i++) tick();
        tests_run += 3;
        if (pulse_cnt != base + 1) begin tests_failed++; $display("FAIL clean_accept: pulses=%0d expected %0d", pulse_cnt - base, 1); end
        if (last_code !== 4'd9) begin tests_failed++; $display("FAIL clean_code: got %0d expected 9", last_code); end
        if (key_down !== 1'b1) begin tests_failed++; $display("FAIL clean_down: got %b expected 1", key_down); end
        tick(20);
        tests_run++;
        if (pulse_cnt != base + 1) begin tests_failed++; $display("FAIL clean_single: pulses=%0d expected 1", pulse_cnt - base); end
        // Drop lands 2 sync + 1 detect + 20 stable-release cycles after the edge.
        keys[9] = 1'b0;
        tick(22);
        tests_run++;
        if (key_down !== 1'b1) begin tests_failed++; $display("FAIL clean_down_hold: got %b expected 1", key_down); end
        tick();
        tests_run += 2;
        if (key_down !== 1'b0) begin tests_failed++; $display("FAIL clean_down_drop: got %b expected 0", key_down); end
        if (key_code !== 4'd9) begin tests_failed++; $display("FAIL clean_code_hold: got %0d expected 9", key_code); end
        wait_idle("clean");
    endtask

    task automatic test_bounce();
        int base = pulse_cnt;
        repeat (2) begin
            keys[3] = 1'b1; tick(5);
            keys[3] = 1'b0; tick(5);
        end
        tests_run += 2;
        if (pulse_cnt != base) begin tests_failed++; $display("FAIL bounce_nopulse: pulses=%0d expected 0", pulse_cnt - base); end
        if (key_down !== 1'b0) begin tests_failed++; $display("FAIL bounce_nodown: got %b expected 0", key_down); end
        keys[3] = 1'b1;
        for (int i = 0; i < 60 && pulse_cnt == base; i++) tick();
        tick(20);
        tests_run += 2;
        if (pulse_cnt != base + 1) begin tests_failed++; $display("FAIL bounce_accept: pulses=%0d expected 1", pulse_cnt - base); end
        if (last_code !== 4'd3) begin tests_failed++; $display("FAIL bounce_code: got %0d expected 3", last_code); end
        keys[3] = 1'b0;
        wait_idle("bounce");
    endtask

    task automatic test_release_bounce();
        int base = pulse_cnt;
        bit kd_ok = 1'b1;
        keys[5] = 1'b1;
        for (int i = 0; i < 60 && pulse_cnt == base; i++) tick();
        tests_run++;
        if (last_code !== 4'd5) begin tests_failed++; $display("FAIL rb_code: got %0d expected 5", last_code); end
        keys[5] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (key_down !== 1'b1) kd_ok = 1'b0; end
        keys[5] = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (key_down !== 1'b1) kd_ok = 1'b0; end
        keys[5] = 1'b0;
        for (int i = 0; i < 22; i++) begin tick(); if (key_down !== 1'b1) kd_ok = 1'b0; end
        tests_run++;
        if (kd_ok !== 1'b1) begin tests_failed++; $display("FAIL rb_down_hold: got %b expected 1", kd_ok); end
        tick();
        tests_run += 3;
        if (key_down !== 1'b0) begin tests_failed++; $display("FAIL rb_down_drop: got %b expected 0", key_down); end
        if (pulse_cnt != base + 1) begin tests_failed++; $display("FAIL rb_single: pulses=%0d expected 1", pulse_cnt - base); end
        if (key_code !== 4'd5) begin tests_failed++; $display("FAIL rb_code_hold: got %0d expected 5", key_code); end
        wait_idle("rb");
    endtask

    task automatic test_multi_key();
        int base = pulse_cnt;
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        for (int i = 0; i < 60 && pulse_cnt == base; i++) tick();
        tests_run++;
        if (last_code !== 4'd4) begin tests_failed++; $display("FAIL multi_code: got %0d expected 4", last_code); end
        keys[12] = 1'b1;
        tick(30);
        tests_run += 4;
        if (pulse_cnt != base + 1) begin tests_failed++; $display("FAIL multi_ignore: pulses=%0d expected 1", pulse_cnt - base); end
        if (key_code !== 4'd4) begin tests_failed++; $display("FAIL multi_code_hold: got %0d expected 4", key_code); end
        if (key_down !== 1'b1) begin tests_failed++; $display("FAIL multi_down: got %b expected 1", key_down); end
        if (row_n !== 4'b1101) begin tests_failed++; $display("FAIL multi_row_frozen: row_n=%b expected 1101", row_n); end
        keys = '0;
        wait_idle("multi");
    endtask

    task automatic test_reset_mid_debounce();
        int base = pulse_cnt;
        for (int i = 0; i < 40 && row_n !== 4'b1110; i++) tick();
        for (int i = 0; i < 40 && row_n !== 4'b1101; i++) tick();
        tests_run++;
        if (row_n !== 4'b1101) begin tests_failed++; $display("FAIL rmd_sync: row_n=%b expected 1101", row_n); end
        // Row 1 starts now; row 2 is sampled 8 cycles later and DEBOUNCE begins.
        keys[10] = 1'b1;
        tick(17);
        tests_run++;
        if (row_n !== 4'b1011) begin tests_failed++; $display("FAIL rmd_frozen: row_n=%b expected 1011", row_n); end
        tick();
        rst = 1'b0;
        #1;
        tests_run += 4;
        if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL rmd_row_n: got %b expected 1110", row_n); end
        if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL rmd_valid: got %b expected 0", key_valid); end
        if (key_down !== 1'b0) begin tests_failed++; $display("FAIL rmd_down: got %b expected 0", key_down); end
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL rmd_code: got %0d expected 0", key_code); end
        keys = '0;
        tick(3);
        rst = 1'b1;
        tests_run++;
        if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL rmd_restart0: row_n=%b expected 1110", row_n); end
        tick(4);
        tests_run++;
        if (row_n !== 4'b1101) begin tests_failed++; $display("FAIL rmd_restart1: row_n=%b expected 1101", row_n); end
        tick(30);
        tests_run++;
        if (pulse_cnt != base) begin tests_failed++; $display("FAIL rmd_nopulse: pulses=%0d expected 0", pulse_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_multi_key();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows driven.
REQ-002 Parameter COLS, default 4, number of matrix columns sensed.
REQ-003 Parameter DWELL, default 4, clk1k cycles each row is driven during scanning.
REQ-004 Parameter DEBOUNCE, default 20, clk1k cycles (ms) of stable input required for press and release.
REQ-005 clk1k  input  1  1 kHz scan clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 col_n  input  COLS  column sense lines, active-low (pulled high, low = key closed), asynchronous to clk1k.
REQ-008 row_n  output  ROWS  row drive, one-cold active-low (exactly one bit low at all times after reset).
REQ-009 key_code  output  4  encoded key = row_index*COLS + col_index of the accepted key.
REQ-010 key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-011 key_down  output  1  level, high while the accepted key is held (through release debounce).

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer (reset value all-ones) before any use; "cols" below means the synchronized value.
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 SCAN: row index SHALL advance every DWELL cycles, 0,1,...,ROWS-1, wrapping to 0; row_n = ~(1<<row_index).
REQ-015 SCAN: on the last dwell cycle of a row, if cols != all-ones, the FSM SHALL latch the pattern, capture col_index = lowest-numbered low bit, hold the row, clear the debounce counter, and go to DEBOUNCE.
REQ-016 DEBOUNCE: the row SHALL stay frozen; each cycle the counter SHALL increment while cols equals the latched pattern; any mismatch SHALL return to SCAN, advancing to the next row with no output change.
REQ-017 DEBOUNCE: when the counter reaches DEBOUNCE-1 with a match, the FSM SHALL go to PRESSED, load key_code, assert key_valid for exactly that one cycle, and set key_down.
REQ-018 PRESSED: the row SHALL stay frozen; additional keys in the same row SHALL be ignored; when cols == all-ones, the FSM SHALL clear the counter and go to RELEASE.
REQ-019 RELEASE: the counter SHALL increment while cols == all-ones; any low column SHALL return to PRESSED with no new key_valid pulse and key_code unchanged.
REQ-020 RELEASE: when the counter reaches DEBOUNCE-1, the FSM SHALL clear key_down and return to SCAN at the next row.
REQ-021 key_code SHALL hold its last value until the next accepted press.
REQ-022 Minimum press-to-key_valid latency SHALL be 2 (sync) + DEBOUNCE cycles after the sampling cycle.
REQ-023 The debounce counter SHALL be ceil(log2(DEBOUNCE+1)) bits wide and never wrap.
REQ-024 Keys in rows not currently driven SHALL have no effect.

Reset
REQ-025 While rst is low: state SCAN, row index 0, row_n = all-ones except bit 0 low, key_code 0, key_valid 0, key_down 0, counters 0, synchronizer all-ones.
REQ-026 Reset assertion mid-debounce or mid-press SHALL abort immediately with no key_valid pulse; after release, scanning SHALL restart at row 0.

Structure
REQ-027 The shared package keypad_pkg SHALL hold the FSM state enum and the default ROWS, COLS, DWELL and DEBOUNCE constants.
REQ-028 The 2-flop synchronizer SHALL be the single sub-module col_sync, parameterized by width.
REQ-029 The implementation SHALL be 120-400 lines of RTL with no latches; all flops SHALL be reset by rst.

Verification
REQ-030 Reset check: hold rst low 3 cycles -> row_n=1110, key_valid=0, key_down=0, key_code=0; after release, row_n steps 1110->1101->1011->0111->1110 every 4 cycles.
REQ-031 Clean press: hold key row 2 col 1 (col_n=1101 while row_n=1011) for 40 ms -> one key_valid pulse with key_code=9, key_down high until 20 cycles after release.
REQ-032 Bounce: toggle key row 0 col 3 every 5 ms for 15 ms, then hold 30 ms -> no pulse during bouncing, exactly one pulse with key_code=3 after stable hold.
REQ-033 Release bounce: press key 5 stably, then release with a 3 ms re-closure at 10 ms into RELEASE -> key_down stays high, no second pulse, key_down drops 20 cycles after final release.
REQ-034 Multi-key: keys row 1 cols 0 and 2 pressed simultaneously -> key_code=4 (lowest column); a key in row 3 pressed during PRESSED -> ignored.
REQ-035 Reset mid-debounce: assert rst 10 cycles into DEBOUNCE -> no key_valid pulse, outputs at reset values, scan restarts at row 0.
